// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions: opcodes (also used by the control decoder),
// the symbolic instruction classes and the program-loader FSM states.
package rv_isa_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_OP      = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_OP_IMM  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_JALR    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer: builds the machine word for one symbolic
// instruction and flags illegal classes and odd branch/jump offsets.
module rv_instr_pack
    import rv_isa_pkg::*;
(
    input  instr_class_t cls,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic [20:0]  imm,
    output logic [31:0]  word,
    output logic         illegal,
    output logic         misalign
);

    always_comb begin
        word     = '0;
        illegal  = 1'b0;
        misalign = 1'b0;
        case (cls)
            CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_OP:     word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
            CLS_BRANCH: begin
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                misalign = imm[0];
            end
            CLS_OP_IMM: begin
                // Shifts carry the arithmetic bit and a 5-bit shamt instead of imm[11:5]
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                else
                    word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
            end
            CLS_JAL: begin
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                misalign = imm[0];
            end
            CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_program_encoder.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes them
// and writes them to IMEM at an auto-incrementing word address.
module rv_program_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [20:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_align,
    output logic              err_full
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    load_state_t state, state_next;
    logic        full;
    logic        accept;
    logic        write_ok;
    logic [31:0] packed_word;
    logic        pk_illegal;
    logic        pk_misalign;

    rv_instr_pack u_pack (
        .cls      (instr_class_t'(in_class)),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .word     (packed_word),
        .illegal  (pk_illegal),
        .misalign (pk_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (start)       state_next = ST_LOAD;
                else if (finish) state_next = ST_DONE;
            end
            ST_DONE: if (start) state_next = ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_LOAD);
        done     = (state == ST_DONE);
        in_ready = (state == ST_LOAD) && !err_full && !full && !finish;
    end

    assign full     = (count == DEPTH_CNT);
    assign accept   = in_valid && in_ready;
    assign write_ok = accept && !pk_illegal;

    // The write address is captured at accept, so a start in the same cycle
    // still lets that write land at the old address while the counter clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            err_align   <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we <= write_ok;
            if (write_ok) begin
                imem_addr  <= count[ADDR_W-1:0];
                imem_wdata <= packed_word;
            end
            if (start) begin
                count       <= '0;
                err_illegal <= 1'b0;
                err_align   <= 1'b0;
                err_full    <= 1'b0;
            end else begin
                if (write_ok)                 count       <= count + CNT_ONE;
                if (accept && pk_illegal)     err_illegal <= 1'b1;
                if (accept && pk_misalign)    err_align   <= 1'b1;
                if (busy && in_valid && full) err_full    <= 1'b1;
            end
        end
    end

endmodule
